// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: CHUNK bits per cycle, MSB chunk first, early exit.
// Optional two's-complement ordering when SEQ_COMP_SIGNED_EN is defined.
module seq_mag_comp #(
  parameter  int WIDTH  = 8,
  parameter  int CHUNK  = 2,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             aeqb,
  output logic             agtb,
  output logic             altb,
  output logic [IW-1:0]    diff_idx
);

  typedef enum logic {IDLE, CMP} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

`ifdef SEQ_COMP_SIGNED_EN
  localparam logic [WIDTH-1:0] SIGN_MASK = WIDTH'(1) << (WIDTH - 1);
`endif

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_a, r_b, w_a_n, w_b_n;
  logic [IW-1:0]    r_idx, w_idx_n;
  logic             r_busy, w_busy_n;
  logic             r_done, w_done_n;
  logic             r_aeqb, w_aeqb_n;
  logic             r_agtb, w_agtb_n;
  logic             r_altb, w_altb_n;
  logic [IW-1:0]    r_diff_idx, w_diff_idx_n;

  logic [WIDTH-1:0] w_sh_a, w_sh_b;
  logic [CHUNK-1:0] w_ca, w_cb;

  // Shift the current chunk to the top instead of a variable part-select.
  assign w_sh_a = r_a << (32'(r_idx) * CHUNK);
  assign w_sh_b = r_b << (32'(r_idx) * CHUNK);
  assign w_ca   = w_sh_a[WIDTH-1 -: CHUNK];
  assign w_cb   = w_sh_b[WIDTH-1 -: CHUNK];

  always_comb begin
    w_state_n    = r_state;
    w_a_n        = r_a;
    w_b_n        = r_b;
    w_idx_n      = r_idx;
    w_busy_n     = r_busy;
    w_done_n     = 1'b0;
    w_aeqb_n     = r_aeqb;
    w_agtb_n     = r_agtb;
    w_altb_n     = r_altb;
    w_diff_idx_n = r_diff_idx;
    unique case (r_state)
      IDLE: begin
        if (start) begin
`ifdef SEQ_COMP_SIGNED_EN
          // Offset-binary: flipping the sign bit makes unsigned order match signed order.
          w_a_n = a ^ SIGN_MASK;
          w_b_n = b ^ SIGN_MASK;
`else
          w_a_n = a;
          w_b_n = b;
`endif
          w_idx_n   = '0;
          w_busy_n  = 1'b1;
          w_state_n = CMP;
        end
      end
      CMP: begin
        if (w_ca != w_cb) begin
          w_aeqb_n     = 1'b0;
          w_agtb_n     = (w_ca > w_cb);
          w_altb_n     = (w_ca < w_cb);
          w_diff_idx_n = r_idx;
          w_busy_n     = 1'b0;
          w_done_n     = 1'b1;
          w_state_n    = IDLE;
        end else if (r_idx == LAST_IDX) begin
          w_aeqb_n     = 1'b1;
          w_agtb_n     = 1'b0;
          w_altb_n     = 1'b0;
          w_diff_idx_n = LAST_IDX;
          w_busy_n     = 1'b0;
          w_done_n     = 1'b1;
          w_state_n    = IDLE;
        end else begin
          w_idx_n = r_idx + IW'(1);
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_aeqb     <= 1'b0;
      r_agtb     <= 1'b0;
      r_altb     <= 1'b0;
      r_diff_idx <= '0;
    end else begin
      r_state    <= w_state_n;
      r_a        <= w_a_n;
      r_b        <= w_b_n;
      r_idx      <= w_idx_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
      r_aeqb     <= w_aeqb_n;
      r_agtb     <= w_agtb_n;
      r_altb     <= w_altb_n;
      r_diff_idx <= w_diff_idx_n;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign aeqb     = r_aeqb;
  assign agtb     = r_agtb;
  assign altb     = r_altb;
  assign diff_idx = r_diff_idx;

endmodule
